pad_stream: RTL and testbench
=============================

# pad_stream

Parametrised border-padding stage between the demosaic output and the FIFO convolution filter. It accepts a raster pixel stream of WIDTH×HEIGHT multi-channel pixels and emits the padded (WIDTH+2B)×(HEIGHT+2B) stream the kernel needs, where B=(KERNEL-1)/2. Border pixels are either zero or clamped (replicated edge), selected per frame. This replaces ad-hoc blank insertion in the processing top level. It adds input back-pressure, so the stage never drops or mistimes border pixels for any kernel size.

## Interface
- WIDTH, 320, active pixels per input row (≥2)
- HEIGHT, 240, active rows per frame (≥2)
- KERNEL, 3, filter kernel size; odd, 3..9; B=(KERNEL-1)/2
- CHANNELS, 3, channels per pixel
- DW, 8, bits per channel
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- iMode  in  1  0 = zero padding, 1 = replicate edge; sampled on first accepted pixel of a frame
- iValid  in  1  input pixel valid
- iReady  out  1  stage can accept; beat transfers when iValid&iReady
- iData  in  CHANNELS*DW  input pixel, channel 0 in MSBs
- oValid  out  1  output pixel valid; downstream always accepts
- oData  out  CHANNELS*DW  padded output pixel
- oSof  out  1  with oValid on padded pixel (0,0)
- oEol  out  1  with oValid on last pixel of each padded row
- oDone  out  1  one-cycle pulse with the last padded pixel of a frame

## Operation
- Storage: two row buffers (ping-pong), each WIDTH×CHANNELS*DW, with synchronous-read RAM. Input row k is written to buffer k%2.
- Input counters: column ix 0..WIDTH-1, row iy 0..HEIGHT-1. rowsDone increments on acceptance of column WIDTH-1.
- iReady=1 when either condition holds:
  - iy<2, or
  - output row counter oy > (iy-2)+B, i.e. every output row reading source row iy-2 is finished.
- iReady=0 once all HEIGHT rows of the current frame are accepted, until oDone.
- Output generator walks padded coordinates ox 0..WIDTH+2B-1, oy 0..HEIGHT+2B-1, at one step per cycle.
  - Source row sy=clamp(oy-B,0,HEIGHT-1).
  - Source column sx=clamp(ox-B,0,WIDTH-1).
  - The generator steps only while rowsDone>sy. Otherwise it holds and oValid=0.
- Border pixel (ox<B, ox≥WIDTH+B, oy<B or oy≥HEIGHT+B):
  - Zero mode outputs 0.
  - Replicate mode outputs buffer[sy%2][sx].
- Interior pixels always come from the buffer.
- States: IDLE (no rows buffered), RUN (generating), FLUSH (all input accepted, emitting bottom border rows), DONE (one cycle: counters clear, return to IDLE).
  - IDLE→RUN when rowsDone becomes 1.
  - RUN→FLUSH when rowsDone=HEIGHT.
  - FLUSH→DONE on the last padded pixel.
- Next frame: input for the next frame may begin only after DONE. Mode is latched per frame; a change of iMode mid-frame is ignored.
- Reset mid-frame clears all counters and flags and discards the partial frame. Buffer contents are not cleared and are not observable.

## Timing
- Reset values: oValid=0, oData=0, oSof=0, oEol=0, oDone=0, FSM=IDLE, all counters 0. iReady=1 in the first cycle after reset.
- iReady is combinational from registered state only; it never depends on iValid.
- Latency: accepting edge of pixel (WIDTH-1,0) = E. The generator issues its first read at E+1. oValid/oData for padded pixel (0,0) are registered at E+2.
- Pipeline: constant 2-cycle pipeline from generator step to output register. Stalls insert oValid=0 bubbles and never repeat or skip a pixel.
- Throughput: with continuous iValid, output gaps occur only while waiting on a row.
- Pixel count: exactly (WIDTH+2B)(HEIGHT+2B) oValid beats per frame. oDone coincides with the final beat and asserts together with oEol.
- Simultaneous events: a write to buffer k%2 and a read of buffer (k-1)%2 in the same cycle are legal. A read and write of the same buffer never coincide, because the iReady rule prevents it.

## Test plan
- Zero mode, WIDTH=4, HEIGHT=3, KERNEL=3, CHANNELS=1, input 1..12 continuous -> 30 beats:
  - row0 = 0,0,0,0,0,0
  - row1 = 0,1,2,3,4,0
  - row3 = 0,9,10,11,12,0
  - row4 = all 0
  - oSof on beat 1, oEol every 6th beat, oDone on beat 30.
- Replicate mode, same frame -> 30 beats:
  - row0 = row1 = 1,1,2,3,4,4
  - row4 = 9,9,10,11,12,12
- First-pixel latency: continuous input, accept pixel 4 at edge E -> first oValid registered at E+2.
- Back-pressure: WIDTH=8, HEIGHT=6, KERNEL=7, random iValid -> iReady drops while rows are still needed; 168 beats, outputs match the zero-pad model, no lost input beats.
- Reset mid-frame: assert reset after 7 accepted pixels, then send a full frame -> next oValid occurs only after the new row0 completes, and the output matches a clean frame.
- Back-to-back frames, second with iMode flipped mid-frame -> first frame completes with oDone. The second frame uses the mode sampled at its first pixel, and the mid-frame iMode change is ignored.

Source files
------------

// File: rtl/pad_stream_if.sv
// Pixel stream bundle around pad_stream: upstream handshake in, padded raster out.
// master drives the input side, slave is the padding stage itself.
interface pad_stream_if #(
  parameter int DATA_W = 24
);
  logic              iMode;
  logic              iValid;
  logic              iReady;
  logic [DATA_W-1:0] iData;
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic              oSof;
  logic              oEol;
  logic              oDone;

  modport master (
    output iMode, iValid, iData,
    input  iReady, oValid, oData, oSof, oEol, oDone
  );

  modport slave (
    input  iMode, iValid, iData,
    output iReady, oValid, oData, oSof, oEol, oDone
  );
endinterface

// File: rtl/pad_stream.sv
// Border-padding stage: buffers two source rows (ping-pong) and walks the padded
// (WIDTH+2B)x(HEIGHT+2B) raster, emitting zero or replicated-edge border pixels.
module pad_stream #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int KERNEL   = 3,
  parameter int CHANNELS = 3,
  parameter int DW       = 8
) (
  input logic         clk,
  input logic         reset,
  pad_stream_if.slave bus
);
  localparam int DATA_W = CHANNELS * DW;
  localparam int B      = (KERNEL - 1) / 2;
  localparam int PW     = WIDTH + 2 * B;
  localparam int PH     = HEIGHT + 2 * B;
  localparam int IXW    = $clog2(WIDTH);
  localparam int IYW    = $clog2(HEIGHT + 1);
  localparam int OXW    = $clog2(PW);
  localparam int OYW    = $clog2(PH);

  localparam logic [IXW-1:0] IX_LAST = IXW'(WIDTH - 1);
  localparam logic [IYW-1:0] IY_FULL = IYW'(HEIGHT);
  localparam logic [OXW-1:0] OX_LAST = OXW'(PW - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(PH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [IXW-1:0]    ix_q, ix_d;
  logic [IYW-1:0]    rows_done_q, rows_done_d;
  logic              mode_q, mode_d;
  logic [OXW-1:0]    ox_q, ox_d;
  logic [OYW-1:0]    oy_q, oy_d;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_zero_q, s1_zero_d;
  logic              s1_sof_q, s1_sof_d;
  logic              s1_eol_q, s1_eol_d;
  logic              s1_last_q, s1_last_d;
  logic [DATA_W-1:0] rd_data_q;

  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              o_sof_q, o_sof_d;
  logic              o_eol_q, o_eol_d;
  logic              o_done_q, o_done_d;

  logic [IXW-1:0]    sx;
  logic [IYW-1:0]    sy;
  logic              in_left, in_right, in_top, in_bottom, border;
  logic              last_px, step, in_full, i_ready, accept;

  // Padded coordinate -> clamped source coordinate and border classification.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    in_left   = 32'(ox_q) < 32'(B);
    in_right  = 32'(ox_q) >= 32'(WIDTH + B);
    in_top    = 32'(oy_q) < 32'(B);
    in_bottom = 32'(oy_q) >= 32'(HEIGHT + B);
    sx = '0;
    sy = '0;
    if (in_right)     sx = IX_LAST;
    else if (!in_left) sx = IXW'(32'(ox_q) - 32'(B));
    if (in_bottom)    sy = IYW'(HEIGHT - 1);
    else if (!in_top) sy = IYW'(32'(oy_q) - 32'(B));
    border  = in_left || in_right || in_top || in_bottom;
    last_px = (ox_q == OX_LAST) && (oy_q == OY_LAST);
  end

  // A row buffer may be refilled only once the generator has left every row that reads it.
  assign in_full = (rows_done_q == IY_FULL);
  assign i_ready = !in_full &&
                   ((rows_done_q < IYW'(2)) ||
                    ((32'(oy_q) + 32'd2) > (32'(rows_done_q) + 32'(B))));
  assign accept  = bus.iValid && i_ready;
  assign step    = (state_q != DONE) && (32'(rows_done_q) > 32'(sy));

  always_comb begin
    state_d     = state_q;
    ix_d        = ix_q;
    rows_done_d = rows_done_q;
    mode_d      = mode_q;
    ox_d        = ox_q;
    oy_d        = oy_q;

    if (accept) begin
      if ((ix_q == '0) && (rows_done_q == '0)) mode_d = bus.iMode;
      if (ix_q == IX_LAST) begin
        ix_d        = '0;
        rows_done_d = rows_done_q + IYW'(1);
      end else begin
        ix_d = ix_q + IXW'(1);
      end
    end

    if (step) begin
      if (ox_q == OX_LAST) begin
        ox_d = '0;
        oy_d = last_px ? '0 : oy_q + OYW'(1);
      end else begin
        ox_d = ox_q + OXW'(1);
      end
    end

    case (state_q)
      IDLE:    if (rows_done_q != '0) state_d = RUN;
      RUN: begin
        if (step && last_px) state_d = DONE;
        else if (in_full)    state_d = FLUSH;
      end
      FLUSH:   if (step && last_px) state_d = DONE;
      DONE: begin
        state_d     = IDLE;
        rows_done_d = '0;
        ix_d        = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = step;
    s1_zero_d  = border && !mode_q;
    s1_sof_d   = step && (ox_q == '0) && (oy_q == '0);
    s1_eol_d   = step && (ox_q == OX_LAST);
    s1_last_d  = step && last_px;

    o_valid_d  = s1_valid_q;
    o_data_d   = (s1_valid_q && !s1_zero_q) ? rd_data_q : '0;
    o_sof_d    = s1_sof_q;
    o_eol_d    = s1_eol_q;
    o_done_d   = s1_last_q;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ix_q        <= '0;
      rows_done_q <= '0;
      mode_q      <= 1'b0;
      ox_q        <= '0;
      oy_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_data_q    <= '0;
      o_sof_q     <= 1'b0;
      o_eol_q     <= 1'b0;
      o_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ix_q        <= ix_d;
      rows_done_q <= rows_done_d;
      mode_q      <= mode_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      s1_valid_q  <= s1_valid_d;
      s1_zero_q   <= s1_zero_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      s1_last_q   <= s1_last_d;
      o_valid_q   <= o_valid_d;
      o_data_q    <= o_data_d;
      o_sof_q     <= o_sof_d;
      o_eol_q     <= o_eol_d;
      o_done_q    <= o_done_d;
    end
  end

  // Ping-pong row storage: source row k lives in buffer k%2.
  // NOTE: the RAM and its read register carry no reset; contents are never seen before being written.
  logic [DATA_W-1:0] row_mem [2][WIDTH];

  always_ff @(posedge clk) begin
    if (accept) row_mem[rows_done_q[0]][ix_q] <= bus.iData;
    if (step)   rd_data_q <= row_mem[sy[0]][sx];
  end

  assign bus.iReady = i_ready;
  assign bus.oValid = o_valid_q;
  assign bus.oData  = o_data_q;
  assign bus.oSof   = o_sof_q;
  assign bus.oEol   = o_eol_q;
  assign bus.oDone  = o_done_q;
endmodule

// File: tb/tb_pad_stream.sv
// Scoreboard bench for pad_stream: two configurations (4x3 K3 and 8x6 K7) driven with
// randomized valid patterns; expected padded frames come from a coordinate-level model.
module tb_pad_stream;
  localparam int AW = 4, AH = 3, AB = 1, APW = AW + 2 * AB, APH = AH + 2 * AB;
  localparam int BW = 8, BH = 6, BB = 3, BPW = BW + 2 * BB, BPH = BH + 2 * BB;

  typedef struct {
    int unsigned data;
    bit          sof;
    bit          eol;
    bit          done;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t exp_a[$];
  beat_t exp_b[$];
  int    e_a = -100, e_b = -100;
  int    done_a = 0, done_b = 0;
  int    beats_a = 0, beats_b = 0;
  bit    stall_b;

  pad_stream_if #(.DATA_W(8))  ifa ();
  pad_stream_if #(.DATA_W(16)) ifb ();

  pad_stream #(.WIDTH(AW), .HEIGHT(AH), .KERNEL(3), .CHANNELS(1), .DW(8)) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa)
  );
  pad_stream #(.WIDTH(BW), .HEIGHT(BH), .KERNEL(7), .CHANNELS(2), .DW(8)) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected padded pixel straight from the clamp/border rules.
  function automatic int unsigned model_pix(input int unsigned frm[$], input int w, input int h,
                                            input int b, input bit mode, input int ox, input int oy);
    int sx, sy;
    bit border;
    sx = (ox < b) ? 0 : ((ox - b >= w) ? w - 1 : ox - b);
    sy = (oy < b) ? 0 : ((oy - b >= h) ? h - 1 : oy - b);
    border = (ox < b) || (ox >= w + b) || (oy < b) || (oy >= h + b);
    return (border && !mode) ? 0 : frm[sy * w + sx];
  endfunction

  task automatic push_frame(input bit to_b, input int unsigned frm[$], input int w, input int h,
                            input int b, input bit mode);
    beat_t bt;
    for (int oy = 0; oy < h + 2 * b; oy++) begin
      for (int ox = 0; ox < w + 2 * b; ox++) begin
        bt.data = model_pix(frm, w, h, b, mode, ox, oy);
        bt.sof  = (ox == 0) && (oy == 0);
        bt.eol  = (ox == w + 2 * b - 1);
        bt.done = bt.eol && (oy == h + 2 * b - 1);
        if (to_b) exp_b.push_back(bt);
        else      exp_a.push_back(bt);
      end
    end
  endtask

  task automatic drive_a(input int unsigned frm[$], input bit mode, input int flip_at,
                         input int pct, input int n_send);
    int i = 0;
    int guard = 0;
    if (n_send == frm.size()) push_frame(1'b0, frm, AW, AH, AB, mode);
    while (i < n_send && guard < 5000) begin
      @(negedge clk);
      guard++;
      ifa.iMode  = (i >= flip_at) ? !mode : mode;
      ifa.iValid = ($urandom_range(99) < pct);
      ifa.iData  = 8'(frm[i]);
      if (ifa.iValid && ifa.iReady) begin
        if (i == AW - 1) e_a = cyc + 1;
        i++;
      end
    end
    if (i < n_send) check("a_input_timeout", i, n_send);
    @(negedge clk);
    ifa.iValid = 1'b0;
  endtask

  task automatic drive_b(input int unsigned frm[$], input bit mode, input int flip_at,
                         input int pct, input int n_send);
    int i = 0;
    int guard = 0;
    if (n_send == frm.size()) push_frame(1'b1, frm, BW, BH, BB, mode);
    while (i < n_send && guard < 5000) begin
      @(negedge clk);
      guard++;
      ifb.iMode  = (i >= flip_at) ? !mode : mode;
      ifb.iValid = ($urandom_range(99) < pct);
      ifb.iData  = 16'(frm[i]);
      if (i > 0 && !ifb.iReady) stall_b = 1'b1;
      if (ifb.iValid && ifb.iReady) begin
        if (i == BW - 1) e_b = cyc + 1;
        i++;
      end
    end
    if (i < n_send) check("b_input_timeout", i, n_send);
    @(negedge clk);
    ifb.iValid = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    beat_t e;
    if (!reset_a && ifa.oValid) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_beat", 1, 0);
      end else begin
        e = exp_a.pop_front();
        check("a_data", ifa.oData, e.data);
        check("a_flags_sof_eol_done", {ifa.oSof, ifa.oEol, ifa.oDone}, {e.sof, e.eol, e.done});
      end
      if (ifa.oSof) begin
        beats_a = 1;
        check("a_first_pixel_latency", cyc, e_a + 2);
      end else begin
        beats_a++;
      end
      if (ifa.oDone) begin
        check("a_frame_beats", beats_a, APW * APH);
        done_a++;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t e;
    if (!reset_b && ifb.oValid) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_beat", 1, 0);
      end else begin
        e = exp_b.pop_front();
        check("b_data", ifb.oData, e.data);
        check("b_flags_sof_eol_done", {ifb.oSof, ifb.oEol, ifb.oDone}, {e.sof, e.eol, e.done});
      end
      if (ifb.oSof) begin
        beats_b = 1;
        check("b_first_pixel_latency", cyc, e_b + 2);
      end else begin
        beats_b++;
      end
      if (ifb.oDone) begin
        check("b_frame_beats", beats_b, BPW * BPH);
        done_b++;
      end
    end
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    ifa.iValid = 1'b0; ifa.iMode = 1'b0; ifa.iData = '0;
    ifb.iValid = 1'b0; ifb.iMode = 1'b0; ifb.iData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;

    check("a_rst_ovalid", ifa.oValid, 0);
    check("a_rst_odata", ifa.oData, 0);
    check("a_rst_flags", {ifa.oSof, ifa.oEol, ifa.oDone}, 0);
    check("a_rst_iready", ifa.iReady, 1);
    check("b_rst_ovalid", ifb.oValid, 0);
    check("b_rst_iready", ifb.iReady, 1);

    fork
      begin : seq_a
        int unsigned fa[$];
        bit m;
        for (int k = 1; k <= 12; k++) fa.push_back(k);
        drive_a(fa, 1'b0, 1000, 100, 12);   // zero padding, continuous
        drive_a(fa, 1'b1, 1000, 100, 12);   // replicate, back-to-back
        for (int f = 0; f < 3; f++) begin
          fa.delete();
          for (int k = 0; k < 12; k++) fa.push_back($urandom_range(255));
          m = 1'($urandom_range(1));
          drive_a(fa, m, $urandom_range(1, 11), 60, 12);
        end
      end
      begin : seq_b
        int unsigned fb[$];
        for (int k = 0; k < 48; k++) fb.push_back($urandom_range(65535));
        drive_b(fb, 1'b1, 1000, 100, 7);     // partial frame, then reset
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        check("b_midrst_iready", ifb.iReady, 1);
        check("b_midrst_ovalid", ifb.oValid, 0);

        stall_b = 1'b0;
        drive_b(fb, 1'b0, 1000, 50, 48);
        check("b_iready_dropped", stall_b, 1);
        fb.delete();
        for (int k = 0; k < 48; k++) fb.push_back($urandom_range(65535));
        drive_b(fb, 1'b1, 1000, 70, 48);
        fb.delete();
        for (int k = 0; k < 48; k++) fb.push_back($urandom_range(65535));
        drive_b(fb, 1'b0, 20, 100, 48);      // iMode flips after pixel 20
      end
    join

    for (int t = 0; t < 3000 && !(done_a == 5 && done_b == 3); t++) @(negedge clk);
    check("a_frames_done", done_a, 5);
    check("b_frames_done", done_b, 3);
    check("a_scoreboard_empty", exp_a.size(), 0);
    check("b_scoreboard_empty", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
